// File: rtl/spike_argmax_classifier_pkg.sv
// Shared types and helpers for the spike-count argmax classifier.
package spike_argmax_classifier_pkg;

    typedef enum logic [1:0] {
        CLS_IDLE = 2'd0,
        CLS_SCAN = 2'd1,
        CLS_FIN  = 2'd2
    } cls_state_t;

    // Index width that never collapses to zero bits for a single output.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_argmax_classifier_if.sv
// Start/counts request bundle and held classification results.
interface spike_argmax_classifier_if
    import spike_argmax_classifier_pkg::*;
#(
    parameter int NUM_OUTPUTS  = 4,
    parameter int COUNTER_SIZE = 32
);
    localparam int IDX_W = clog2_min1(NUM_OUTPUTS);

    logic                                start;
    logic [NUM_OUTPUTS*COUNTER_SIZE-1:0] counts;
    logic                                busy;
    logic                                done;
    logic [IDX_W-1:0]                    class_idx;
    logic [COUNTER_SIZE-1:0]             max_count;
    logic [COUNTER_SIZE-1:0]             margin;
    logic                                no_spikes;

    modport master (
        output start, counts,
        input  busy, done, class_idx, max_count, margin, no_spikes
    );

    modport slave (
        input  start, counts,
        output busy, done, class_idx, max_count, margin, no_spikes
    );

endinterface

// File: rtl/spike_argmax_classifier.sv
// Scans the packed spike counters one per clock and holds the winner, its count
// and its margin over the runner-up until the next classification.
module spike_argmax_classifier
    import spike_argmax_classifier_pkg::*;
#(
    parameter int NUM_OUTPUTS  = 4,
    parameter int COUNTER_SIZE = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    spike_argmax_classifier_if.slave  bus
);
    localparam int IDX_W = clog2_min1(NUM_OUTPUTS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OUTPUTS - 1);

    cls_state_t              state_q;
    logic [CNT_W-1:0]        idx_q;
    logic [COUNTER_SIZE-1:0] best_q, best_d;
    logic [COUNTER_SIZE-1:0] runner_q, runner_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic [COUNTER_SIZE-1:0] sample_s;

    logic                    busy_q;
    logic                    done_q;
    logic [IDX_W-1:0]        class_idx_q;
    logic [COUNTER_SIZE-1:0] max_count_q;
    logic [COUNTER_SIZE-1:0] margin_q;
    logic                    no_spikes_q;

    // Select the counter addressed by the scan index.
    always_comb begin
        sample_s = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (idx_q == CNT_W'(i)) begin
                sample_s = bus.counts[i*COUNTER_SIZE +: COUNTER_SIZE];
            end else begin
                sample_s = sample_s;
            end
        end
    end

    // Strict comparisons keep the lowest index on ties; an equal count lands in runner-up.
    always_comb begin
        best_d     = best_q;
        runner_d   = runner_q;
        best_idx_d = best_idx_q;
        if (sample_s > best_q) begin
            runner_d   = best_q;
            best_d     = sample_s;
            best_idx_d = idx_q[IDX_W-1:0];
        end else if (sample_s > runner_q) begin
            runner_d = sample_s;
        end else begin
            runner_d = runner_q;
        end
    end

    // Scan FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLS_IDLE;
            idx_q       <= '0;
            best_q      <= '0;
            runner_q    <= '0;
            best_idx_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            class_idx_q <= '0;
            max_count_q <= '0;
            margin_q    <= '0;
            no_spikes_q <= 1'b0;
        end else begin
            case (state_q)
                CLS_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q    <= CLS_SCAN;
                        idx_q      <= '0;
                        best_q     <= '0;
                        runner_q   <= '0;
                        best_idx_q <= '0;
                        busy_q     <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                CLS_SCAN: begin
                    best_q     <= best_d;
                    runner_q   <= runner_d;
                    best_idx_q <= best_idx_d;
                    idx_q      <= idx_q + CNT_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q     <= CLS_FIN;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        class_idx_q <= best_idx_d;
                        max_count_q <= best_d;
                        margin_q    <= best_d - runner_d;
                        no_spikes_q <= (best_d == '0);
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                CLS_FIN: begin
                    state_q <= CLS_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= CLS_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.class_idx = class_idx_q;
    assign bus.max_count = max_count_q;
    assign bus.margin    = margin_q;
    assign bus.no_spikes = no_spikes_q;

endmodule

// File: tb/tb_spike_argmax_classifier.sv
// Directed bench: a timing/argmax model checks the 4-output DUT every cycle,
// literal expectations pin key cycles, and a 1-output DUT covers the degenerate width.
module tb_spike_argmax_classifier;
    import spike_argmax_classifier_pkg::*;

    localparam int N  = 4;
    localparam int CS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spike_argmax_classifier_if #(.NUM_OUTPUTS(N), .COUNTER_SIZE(CS)) ifa ();
    spike_argmax_classifier_if #(.NUM_OUTPUTS(1), .COUNTER_SIZE(CS)) ifb ();

    spike_argmax_classifier #(.NUM_OUTPUTS(N), .COUNTER_SIZE(CS)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    spike_argmax_classifier #(.NUM_OUTPUTS(1), .COUNTER_SIZE(CS)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    logic [CS-1:0] cnt_a [N];

    always_comb begin
        ifa.counts = '0;
        for (int i = 0; i < N; i++) ifa.counts[i*CS +: CS] = cnt_a[i];
    end

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    bit          pending = 1'b0;
    int          t_start = 0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic [1:0]  exp_cls = 2'd0;
    logic [31:0] exp_max = 32'd0;
    logic [31:0] exp_margin = 32'd0;
    logic        exp_nos = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: winner is the lowest index holding the maximum; runner-up is the largest other entry.
    initial begin
        int          bi;
        logic [31:0] mx;
        logic [31:0] sec;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                pending    = 1'b0;
                exp_busy   = 1'b0;
                exp_done   = 1'b0;
                exp_cls    = 2'd0;
                exp_max    = 32'd0;
                exp_margin = 32'd0;
                exp_nos    = 1'b0;
            end else begin
                if (pending && cyc == t_start + N + 2) begin
                    pending = 1'b0;
                end else if (!pending && ifa.start) begin
                    pending = 1'b1;
                    t_start = cyc - 1;
                end
                exp_done = pending && (cyc == t_start + N + 1);
                exp_busy = pending && (cyc <= t_start + N);
                if (exp_done) begin
                    mx = 32'd0;
                    foreach (cnt_a[i]) if (cnt_a[i] > mx) mx = cnt_a[i];
                    bi = -1;
                    foreach (cnt_a[i]) if (bi < 0 && cnt_a[i] == mx) bi = i;
                    sec = 32'd0;
                    foreach (cnt_a[i]) if (i != bi && cnt_a[i] > sec) sec = cnt_a[i];
                    exp_cls    = 2'(bi);
                    exp_max    = mx;
                    exp_margin = mx - sec;
                    exp_nos    = (mx == 32'd0);
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                chk("busy",      64'(ifa.busy),      64'(exp_busy));
                chk("done",      64'(ifa.done),      64'(exp_done));
                chk("class_idx", 64'(ifa.class_idx), 64'(exp_cls));
                chk("max_count", 64'(ifa.max_count), 64'(exp_max));
                chk("margin",    64'(ifa.margin),    64'(exp_margin));
                chk("no_spikes", 64'(ifa.no_spikes), 64'(exp_nos));
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(posedge clk);
        #1;
    endtask

    task automatic pulse_a();
        ifa.start = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
    endtask

    task automatic set_counts(input logic [31:0] c0, c1, c2, c3);
        cnt_a[0] = c0;
        cnt_a[1] = c1;
        cnt_a[2] = c2;
        cnt_a[3] = c3;
    endtask

    task automatic lit_results(input string tag, input logic [1:0] c, input logic [31:0] m,
                               input logic [31:0] g, input logic n);
        chk({tag, "_done"},   64'(ifa.done),      64'd1);
        chk({tag, "_class"},  64'(ifa.class_idx), 64'(c));
        chk({tag, "_max"},    64'(ifa.max_count), 64'(m));
        chk({tag, "_margin"}, 64'(ifa.margin),    64'(g));
        chk({tag, "_nospk"},  64'(ifa.no_spikes), 64'(n));
    endtask

    initial begin
        int t;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifb.counts = 32'd0;
        set_counts(32'd0, 32'd0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_max",  64'(ifa.max_count), 64'd0);
        chk("reset_busy", 64'(ifa.busy),      64'd0);
        chk("reset_b_max", 64'(ifb.max_count), 64'd0);

        // Scenario 1: distinct counts.
        set_counts(32'd3, 32'd9, 32'd2, 32'd5);
        goto(cyc + 1);
        t = cyc;
        pulse_a();
        goto(t + 4);
        chk("s1_not_early", 64'(ifa.done), 64'd0);
        goto(t + 5);
        lit_results("s1", 2'd1, 32'd9, 32'd4, 1'b0);
        goto(t + 6);
        chk("s1_done_drop", 64'(ifa.done), 64'd0);
        chk("s1_held",      64'(ifa.max_count), 64'd9);

        // Scenario 2: tie at the top.
        set_counts(32'd7, 32'd7, 32'd1, 32'd0);
        goto(cyc + 1);
        t = cyc;
        pulse_a();
        goto(t + 5);
        lit_results("s2", 2'd0, 32'd7, 32'd0, 1'b0);

        // Scenario 3: no spikes anywhere.
        set_counts(32'd0, 32'd0, 32'd0, 32'd0);
        goto(cyc + 2);
        t = cyc;
        pulse_a();
        goto(t + 5);
        lit_results("s3", 2'd0, 32'd0, 32'd0, 1'b1);

        // Scenario 4: start during scan is ignored; a later start is accepted.
        set_counts(32'd3, 32'd9, 32'd2, 32'd5);
        goto(cyc + 2);
        t = cyc;
        pulse_a();
        goto(t + 2);
        pulse_a();
        goto(t + 5);
        lit_results("s4", 2'd1, 32'd9, 32'd4, 1'b0);
        goto(t + 7);
        pulse_a();
        goto(t + 11);
        chk("s4_second_early", 64'(ifa.done), 64'd0);
        goto(t + 12);
        chk("s4_second_done", 64'(ifa.done), 64'd1);

        // Scenario 5: reset mid-scan aborts, then a fresh scan works.
        set_counts(32'd1, 32'd2, 32'd3, 32'd4);
        goto(cyc + 2);
        t = cyc;
        pulse_a();
        goto(t + 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("s5_rst_max",   64'(ifa.max_count), 64'd0);
        chk("s5_rst_class", 64'(ifa.class_idx), 64'd0);
        chk("s5_rst_busy",  64'(ifa.busy),      64'd0);
        goto(t + 5);
        chk("s5_no_done", 64'(ifa.done), 64'd0);
        goto(cyc + 2);
        t = cyc;
        pulse_a();
        goto(t + 5);
        lit_results("s5", 2'd3, 32'd4, 32'd1, 1'b0);

        // Scenario 6: single-output instance.
        ifb.counts = 32'hFFFF_FFFF;
        goto(cyc + 2);
        t = cyc;
        ifb.start = 1'b1;
        @(posedge clk);
        #1;
        ifb.start = 1'b0;
        chk("s6_busy", 64'(ifb.busy), 64'd1);
        goto(t + 2);
        chk("s6_done",   64'(ifb.done),      64'd1);
        chk("s6_class",  64'(ifb.class_idx), 64'd0);
        chk("s6_max",    64'(ifb.max_count), 64'hFFFF_FFFF);
        chk("s6_margin", 64'(ifb.margin),    64'hFFFF_FFFF);
        chk("s6_nospk",  64'(ifb.no_spikes), 64'd0);
        goto(t + 3);
        chk("s6_done_drop", 64'(ifb.done), 64'd0);

        goto(cyc + 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
